sprite_pos_scheduler: RTL and testbench

//  Shares the sprite-position registers that drive the 640x480 VGA renderer (X_pos/Y_pos offsets) among
//  NUM_REQ move requesters (keypad, UART, demo sequencer). Grants one move per cycle round-robin and

---
 rtl/vga_sprite_pkg.sv | 40 ++++
 rtl/sprite_pos_scheduler_rr_arbiter.sv | 54 +++++
 rtl/sprite_pos_scheduler.sv | 184 ++++++++++++++++++
 tb/tb_sprite_pos_scheduler.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/vga_sprite_pkg.sv
// rtl/vga_sprite_pkg.sv - shared VGA 640x480 timing, sprite bounds and scheduler types
// Contents:
//   H_*/V_*            640x480@60 timing (active/front porch/sync/back porch/period)
//   SPRITE_W/SPRITE_H  sprite footprint in pixels
//   SPR_{X,Y}_{MIN,MAX} default legal offset range of the sprite origin
//   sched_state_t      scheduler FSM states
//   axis_fit_t         result of fitting one axis sum into its legal range
package vga_sprite_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FRONT  = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BACK   = 48;
  localparam int H_PERIOD = 800;
  localparam int V_ACTIVE = 480;
  localparam int V_FRONT  = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BACK   = 33;
  localparam int V_PERIOD = 525;

  localparam int SPRITE_W = 5;
  localparam int SPRITE_H = 5;

  localparam int SPR_X_MIN = -295;
  localparam int SPR_X_MAX = 340;
  localparam int SPR_Y_MIN = -225;
  localparam int SPR_Y_MAX = 215;

  localparam int POS_W = 10;
  // Wide enough for pos + acc without overflow.
  localparam int SUM_W = 12;

  typedef enum logic {S_ACCEPT, S_COMMIT} sched_state_t;

  typedef struct packed {
    logic             hit;
    logic [POS_W-1:0] pos;
  } axis_fit_t;

endpackage

// File: rtl/sprite_pos_scheduler_rr_arbiter.sv
// rtl/sprite_pos_scheduler_rr_arbiter.sv - round-robin one-hot arbiter with registered pointer
// Ports:
//   i_clk, i_rst  clock, synchronous active-high reset
//   i_req [N]     request vector
//   i_en          arbitration enable; no grant and no pointer move when low
//   o_grant [N]   one-hot grant, combinational from pointer and i_req
module rr_arbiter #(
  parameter int N = 3
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [N-1:0] i_req,
  input  logic         i_en,
  output logic [N-1:0] o_grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] r_ptr;
  logic [PW-1:0] w_next_ptr;
  logic [PW-1:0] w_idx;
  logic [PW:0]   w_wrap;
  logic          w_found;

  // Scan from the pointer upward, wrapping modulo N; first hit wins.
  always_comb begin
    o_grant    = '0;
    w_found    = 1'b0;
    w_next_ptr = r_ptr;
    w_idx      = '0;
    w_wrap     = '0;
    for (int k = 0; k < N; k++) begin
      w_wrap = {1'b0, r_ptr} + (PW+1)'(k);
      if (w_wrap >= (PW+1)'(N)) begin
        w_wrap = w_wrap - (PW+1)'(N);
      end
      w_idx = w_wrap[PW-1:0];
      if (!w_found && i_en && i_req[w_idx]) begin
        w_found        = 1'b1;
        o_grant[w_idx] = 1'b1;
        w_next_ptr     = (w_idx == PW'(N-1)) ? '0 : w_idx + PW'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr <= '0;
    end else if (w_found) begin
      r_ptr <= w_next_ptr;
    end
  end

endmodule

// File: rtl/sprite_pos_scheduler.sv
// rtl/sprite_pos_scheduler.sv - arbitrates sprite moves, accumulates deltas, commits once per frame
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_frame_start         1-cycle pulse at the start of each frame
//   i_req [NUM_REQ]       move requests, held until acked
//   i_dx/i_dy             packed signed STEP_W steps per requester
//   i_center              pulse: recentre to (0,0) at the next commit
//   o_ack [NUM_REQ]       one-hot 1-cycle grant
//   o_x_pos/o_y_pos       committed 10-bit two's complement offsets
//   o_commit              pulse when a commit lands in o_x_pos/o_y_pos
//   o_clamped             pulse with o_commit when either axis hit a bound
// Build option: SPRITE_POS_WRAP_EN defined makes out-of-range sums wrap
// around the legal range instead of saturating.
module sprite_pos_scheduler
  import vga_sprite_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int STEP_W  = 4,
  parameter int ACC_W   = 8,
  parameter int X_MIN   = SPR_X_MIN,
  parameter int X_MAX   = SPR_X_MAX,
  parameter int Y_MIN   = SPR_Y_MIN,
  parameter int Y_MAX   = SPR_Y_MAX
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_frame_start,
  input  logic [NUM_REQ-1:0]        i_req,
  input  logic [NUM_REQ*STEP_W-1:0] i_dx,
  input  logic [NUM_REQ*STEP_W-1:0] i_dy,
  input  logic                      i_center,
  output logic [NUM_REQ-1:0]        o_ack,
  output logic [POS_W-1:0]          o_x_pos,
  output logic [POS_W-1:0]          o_y_pos,
  output logic                      o_commit,
  output logic                      o_clamped
);

  localparam logic signed [ACC_W:0]   ACC_HI = (ACC_W+1)'((2**(ACC_W-1)) - 1);
  localparam logic signed [ACC_W:0]   ACC_LO = -ACC_HI;
  localparam logic signed [SUM_W-1:0] XLO    = SUM_W'(X_MIN);
  localparam logic signed [SUM_W-1:0] XHI    = SUM_W'(X_MAX);
  localparam logic signed [SUM_W-1:0] YLO    = SUM_W'(Y_MIN);
  localparam logic signed [SUM_W-1:0] YHI    = SUM_W'(Y_MAX);

  sched_state_t              r_state;
  logic signed [ACC_W-1:0]   r_acc_x, r_acc_y;
  logic signed [POS_W-1:0]   r_x_pos, r_y_pos;
  logic                      r_center_pend;
  logic                      r_commit, r_clamped;

  logic [NUM_REQ-1:0]        w_ack;
  logic                      w_arb_en;
  logic signed [STEP_W-1:0]  w_step_x, w_step_y;
  logic signed [ACC_W:0]     w_acc_sum_x, w_acc_sum_y;
  logic signed [SUM_W-1:0]   w_sum_x, w_sum_y;
  axis_fit_t                 w_fit_x, w_fit_y;

  // No grants during reset or the commit cycle, so nothing is acked and lost.
  assign w_arb_en = (r_state == S_ACCEPT) && !i_rst;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_req   (i_req),
    .i_en    (w_arb_en),
    .o_grant (w_ack)
  );

  always_comb begin
    w_step_x = '0;
    w_step_y = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_ack[i]) begin
        w_step_x = i_dx[i*STEP_W +: STEP_W];
        w_step_y = i_dy[i*STEP_W +: STEP_W];
      end
    end
  end

  // One extra bit of headroom so the saturation test sees the true sum.
  assign w_acc_sum_x = (ACC_W+1)'(r_acc_x) + (ACC_W+1)'(w_step_x);
  assign w_acc_sum_y = (ACC_W+1)'(r_acc_y) + (ACC_W+1)'(w_step_y);

  function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [ACC_W:0] s);
    logic signed [ACC_W:0] r;
    r = s;
    if (s > ACC_HI) begin
      r = ACC_HI;
    end else if (s < ACC_LO) begin
      r = ACC_LO;
    end
    return r[ACC_W-1:0];
  endfunction

  assign w_sum_x = SUM_W'(r_x_pos) + SUM_W'(r_acc_x);
  assign w_sum_y = SUM_W'(r_y_pos) + SUM_W'(r_acc_y);

  // A single wrap correction is enough: |acc| is far below the range span.
  function automatic axis_fit_t fit_axis(input logic signed [SUM_W-1:0] s,
                                         input logic signed [SUM_W-1:0] lo,
                                         input logic signed [SUM_W-1:0] hi);
    axis_fit_t             f;
    logic signed [SUM_W-1:0] t;
    t     = s;
    f.hit = 1'b0;
`ifdef SPRITE_POS_WRAP_EN
    if (s > hi) begin
      t     = s - (hi - lo + 12'sd1);
      f.hit = 1'b1;
    end else if (s < lo) begin
      t     = s + (hi - lo + 12'sd1);
      f.hit = 1'b1;
    end
`else
    if (s > hi) begin
      t     = hi;
      f.hit = 1'b1;
    end else if (s < lo) begin
      t     = lo;
      f.hit = 1'b1;
    end
`endif
    f.pos = t[POS_W-1:0];
    return f;
  endfunction

  assign w_fit_x = fit_axis(w_sum_x, XLO, XHI);
  assign w_fit_y = fit_axis(w_sum_y, YLO, YHI);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= S_ACCEPT;
      r_acc_x       <= '0;
      r_acc_y       <= '0;
      r_x_pos       <= '0;
      r_y_pos       <= '0;
      r_center_pend <= 1'b0;
      r_commit      <= 1'b0;
      r_clamped     <= 1'b0;
    end else begin
      r_commit  <= 1'b0;
      r_clamped <= 1'b0;
      case (r_state)
        S_ACCEPT: begin
          if (|w_ack) begin
            r_acc_x <= sat_acc(w_acc_sum_x);
            r_acc_y <= sat_acc(w_acc_sum_y);
          end
          if (i_center) begin
            r_center_pend <= 1'b1;
          end
          if (i_frame_start) begin
            r_state <= S_COMMIT;
          end
        end
        S_COMMIT: begin
          r_commit <= 1'b1;
          if (r_center_pend) begin
            r_x_pos <= '0;
            r_y_pos <= '0;
          end else begin
            r_x_pos   <= w_fit_x.pos;
            r_y_pos   <= w_fit_y.pos;
            r_clamped <= w_fit_x.hit | w_fit_y.hit;
          end
          r_acc_x       <= '0;
          r_acc_y       <= '0;
          // A centre request arriving now belongs to the next commit.
          r_center_pend <= i_center;
          r_state       <= S_ACCEPT;
        end
        default: r_state <= S_ACCEPT;
      endcase
    end
  end

  assign o_ack     = w_ack;
  assign o_x_pos   = r_x_pos;
  assign o_y_pos   = r_y_pos;
  assign o_commit  = r_commit;
  assign o_clamped = r_clamped;

endmodule

// File: tb/tb_sprite_pos_scheduler.sv
// tb/tb_sprite_pos_scheduler.sv - directed self-checking bench for sprite_pos_scheduler
module tb_sprite_pos_scheduler;

  logic        clk = 1'b0;
  logic        rst, fs, center;
  logic [2:0]  req, ack;
  logic [11:0] dx, dy;
  logic [9:0]  xp, yp;
  logic        commit, clamped;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  sprite_pos_scheduler dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_frame_start (fs),
    .i_req         (req),
    .i_dx          (dx),
    .i_dy          (dy),
    .i_center      (center),
    .o_ack         (ack),
    .o_x_pos       (xp),
    .o_y_pos       (yp),
    .o_commit      (commit),
    .o_clamped     (clamped)
  );

  function automatic logic [9:0] p10(input int v);
    return v[9:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_step(input int r, input int sx, input int sy);
    dx[r*4 +: 4] = sx[3:0];
    dy[r*4 +: 4] = sy[3:0];
  endtask

  // Enters and leaves on a negedge; one grant per cycle for a lone requester.
  task automatic grant_n(input int r, input int sx, input int sy, input int n);
    set_step(r, sx, sy);
    req    = '0;
    req[r] = 1'b1;
    for (int i = 0; i < n; i++) begin
      #1 check("grant_ack", 32'(ack), 32'(req));
      @(negedge clk);
    end
    req = '0;
  endtask

  task automatic frame(input string tag, input int ex, input int ey, input logic ecl);
    fs = 1'b1;
    @(negedge clk);
    fs = 1'b0;
    check({tag, "_commit_early"}, 32'(commit), 32'd0);
    @(negedge clk);
    check({tag, "_commit"}, 32'(commit), 32'd1);
    check({tag, "_x"}, 32'(xp), 32'(p10(ex)));
    check({tag, "_y"}, 32'(yp), 32'(p10(ey)));
    check({tag, "_clamped"}, 32'(clamped), 32'(ecl));
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [2:0] e;
    int         exp3;
    rst = 1'b1; fs = 1'b0; center = 1'b0; req = '0; dx = '0; dy = '0;
    @(negedge clk);
    req = 3'b111;
    #1 check("rst_ack", 32'(ack), 32'd0);
    @(negedge clk);
    check("rst_x", 32'(xp), 32'd0);
    check("rst_y", 32'(yp), 32'd0);
    check("rst_commit", 32'(commit), 32'd0);
    check("rst_clamped", 32'(clamped), 32'd0);
    req = '0;
    rst = 1'b0;

    // Single grant then commit
    grant_n(0, 3, 0, 1);
    frame("t1", 3, 0, 1'b0);

    // Round-robin order with three held requests
    reset_dut();
    set_step(0, 1, 0);
    set_step(1, 2, 1);
    set_step(2, -1, 2);
    req = 3'b111;
    for (int i = 0; i < 6; i++) begin
      e = '0;
      e[i % 3] = 1'b1;
      #1 check("rr_order", 32'(ack), 32'(e));
      @(negedge clk);
    end
    req = '0;
    frame("t2", 4, 6, 1'b0);

    // Accumulator saturation, then the X upper bound
    reset_dut();
    grant_n(0, 7, 0, 40);
    frame("t5", 127, 0, 1'b0);
    grant_n(0, 7, 0, 40);
    frame("t3a", 254, 0, 1'b0);
    grant_n(0, 7, 0, 12);
    frame("t3b", 338, 0, 1'b0);
    grant_n(0, 5, 0, 1);
`ifdef SPRITE_POS_WRAP_EN
    exp3 = -293;
`else
    exp3 = 340;
`endif
    frame("t3_bound", exp3, 0, 1'b1);

    // Grant coincident with frame_start; no grant in S_COMMIT
    reset_dut();
    set_step(0, 0, -4);
    req = 3'b001;
    fs  = 1'b1;
    #1 check("t4_ack_fs", 32'(ack), 32'd1);
    @(negedge clk);
    fs = 1'b0;
    #1 check("t4_ack_commit_state", 32'(ack), 32'd0);
    check("t4_commit_early", 32'(commit), 32'd0);
    req = '0;
    @(negedge clk);
    check("t4_commit", 32'(commit), 32'd1);
    check("t4_y", 32'(yp), 32'(p10(-4)));
    check("t4_x", 32'(xp), 32'd0);
    @(negedge clk);
    check("t4_commit_pulse", 32'(commit), 32'd0);

    // Empty commit keeps positions
    frame("empty", 0, -4, 1'b0);

    // Centre discards pending delta and clears itself
    grant_n(0, 6, 0, 1);
    center = 1'b1;
    @(negedge clk);
    center = 1'b0;
    frame("center", 0, 0, 1'b0);
    grant_n(0, 2, 0, 1);
    frame("after_center", 2, 0, 1'b0);

    // Reset during the commit cycle discards the pending delta
    grant_n(0, 5, 0, 1);
    fs = 1'b1;
    @(negedge clk);
    fs  = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_commit", 32'(commit), 32'd0);
    check("rst_mid_x", 32'(xp), 32'd0);
    @(negedge clk);
    check("rst_mid_commit2", 32'(commit), 32'd0);
    frame("post_reset", 0, 0, 1'b0);

    // Centre raised during S_COMMIT applies at the following commit
    grant_n(0, 3, 0, 1);
    frame("pre_defer", 3, 0, 1'b0);
    fs = 1'b1;
    @(negedge clk);
    fs     = 1'b0;
    center = 1'b1;
    @(negedge clk);
    center = 1'b0;
    check("defer_commit", 32'(commit), 32'd1);
    check("defer_x_kept", 32'(xp), 32'd3);
    frame("center_deferred", 0, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
